// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic phase sequencer: phase states, lamp patterns,
// duration-select codes and the duration clamp.
package traffic_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GREEN  = 2'd1;
  localparam logic [1:0] ST_YELLOW = 2'd2;
  localparam logic [1:0] ST_RED    = 2'd3;

  // Lamp vector is {red, yellow, green}
  localparam logic [2:0] LIGHT_OFF    = 3'b000;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  localparam logic [1:0] CFG_SEL_GREEN  = 2'b00;
  localparam logic [1:0] CFG_SEL_YELLOW = 2'b01;
  localparam logic [1:0] CFG_SEL_RED    = 2'b10;
  localparam logic [1:0] CFG_SEL_NONE   = 2'b11;

  function automatic logic [6:0] clamp_dur(input logic [6:0] value,
                                           input logic [6:0] max_value);
    logic [6:0] result;
    if (value == 7'd0) begin
      result = 7'd1;
    end else if (value > max_value) begin
      result = max_value;
    end else begin
      result = value;
    end
    return result;
  endfunction

  function automatic logic [1:0] next_phase(input logic [1:0] st);
    logic [1:0] result;
    case (st)
      ST_GREEN:  result = ST_YELLOW;
      ST_YELLOW: result = ST_RED;
      default:   result = ST_GREEN;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Second-tick prescaler: counts 0..DIV-1 while enabled, flags the wrapping cycle.
// clr restarts the count so the next full second begins on the following cycle.
module sec_tick_gen #(
  parameter int DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  // Combinational so the sequencer acts on the same edge that wraps the count
  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// One-approach traffic light sequencer: GREEN -> YELLOW -> RED with programmable
// per-phase durations, a 1 Hz countdown, force-next and flashing-yellow idle.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int MAX_SECOND = 99,
  parameter int DEF_GREEN  = 30,
  parameter int DEF_YELLOW = 3,
  parameter int DEF_RED    = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       force_next,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_sel,
  input  logic [6:0] cfg_value,
  output logic       cfg_ready,
  output logic [2:0] light,
  output logic [6:0] remain,
  output logic       phase_done,
  output logic       sec_tick,
  output logic [1:0] dbg_state
);

  localparam logic [6:0] MAX_DUR = 7'(MAX_SECOND);

  logic [1:0] state_q, state_d;
  logic [6:0] remain_q, remain_d;
  logic       blink_q, blink_d;
  logic [2:0] light_q, light_d;
  logic       phase_done_q, sec_tick_q, cfg_ready_q;
  logic [6:0] dur_green_q, dur_yellow_q, dur_red_q;
  logic [6:0] next_dur;
  logic [1:0] adv_state;
  logic       enter, tick, clr;

  sec_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (!pause),
    .clr  (clr),
    .tick (tick)
  );

  assign adv_state = next_phase(state_q);

  always_comb begin
    case (adv_state)
      ST_YELLOW: next_dur = dur_yellow_q;
      ST_RED:    next_dur = dur_red_q;
      default:   next_dur = dur_green_q;
    endcase
  end

  // Per-edge priority: start=0 > force_next > tick > hold
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    blink_d  = blink_q;
    enter    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d  = ST_GREEN;
        remain_d = dur_green_q;
        enter    = 1'b1;
      end else if (tick) begin
        blink_d = !blink_q;
      end
    end else if (!start) begin
      state_d  = ST_IDLE;
      remain_d = 7'd0;
      blink_d  = 1'b0;
    end else if (force_next || (tick && remain_q <= 7'd1)) begin
      state_d  = adv_state;
      remain_d = next_dur;
      enter    = 1'b1;
    end else if (tick) begin
      remain_d = remain_q - 7'd1;
    end
  end

  // Any state change (phase entry or drop to idle) restarts the second
  assign clr = (state_d != state_q);

  always_comb begin
    case (state_d)
      ST_GREEN:  light_d = LIGHT_GREEN;
      ST_YELLOW: light_d = LIGHT_YELLOW;
      ST_RED:    light_d = LIGHT_RED;
      default:   light_d = blink_d ? LIGHT_YELLOW : LIGHT_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      remain_q     <= 7'd0;
      blink_q      <= 1'b0;
      light_q      <= LIGHT_OFF;
      phase_done_q <= 1'b0;
      sec_tick_q   <= 1'b0;
      cfg_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      remain_q     <= remain_d;
      blink_q      <= blink_d;
      light_q      <= light_d;
      phase_done_q <= enter;
      sec_tick_q   <= tick;
      cfg_ready_q  <= 1'b1;
    end
  end

  // cfg handshake: a write is taken on any edge where cfg_valid && cfg_ready;
  // it only updates the stored duration, which is used at the next phase entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dur_green_q  <= 7'(DEF_GREEN);
      dur_yellow_q <= 7'(DEF_YELLOW);
      dur_red_q    <= 7'(DEF_RED);
    end else if (cfg_valid && cfg_ready_q) begin
      case (cfg_sel)
        CFG_SEL_GREEN:  dur_green_q  <= clamp_dur(cfg_value, MAX_DUR);
        CFG_SEL_YELLOW: dur_yellow_q <= clamp_dur(cfg_value, MAX_DUR);
        CFG_SEL_RED:    dur_red_q    <= clamp_dur(cfg_value, MAX_DUR);
        CFG_SEL_NONE:   ;
      endcase
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign light      = light_q;
  assign remain     = remain_q;
  assign phase_done = phase_done_q;
  assign sec_tick   = sec_tick_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Sequences one traffic-light approach through GREEN -> YELLOW -> RED -> GREEN using per-phase second durations. The durations come from the key/switch or IR-remote time-setting path. The block owns the 1 Hz second tick, the per-phase countdown and the "transfer light" (force next phase) request. Its light and remaining-seconds outputs feed the 7-seg display path and the lamp drivers.

Parameters:
TICK_DIV, 50000000, clk cycles per second tick (benches override to 4)
MAX_SECOND, 99, upper clamp for any configured duration
DEF_GREEN, 30, green duration after reset
DEF_YELLOW, 3, yellow duration after reset
DEF_RED, 30, red duration after reset

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  synchronous, active-low reset
start  in  1  1 = run the phase cycle; 0 = IDLE (flashing yellow)
pause  in  1  1 = freeze countdown and prescaler
force_next  in  1  single-cycle pulse: advance to the next phase now
cfg_valid  in  1  duration write request
cfg_sel  in  2  00 green, 01 yellow, 10 red, 11 ignored
cfg_value  in  7  duration in seconds
cfg_ready  out  1  write accepted when cfg_valid & cfg_ready
light  out  3  {red,yellow,green}; one-hot, or all 0
remain  out  7  seconds left in the current phase
phase_done  out  1  one-cycle pulse on every phase change
sec_tick  out  1  one-cycle pulse once per second

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n; it acts only on a clk rising edge while rst_n=0.
- Reset values: state=IDLE, light=000, remain=0, phase_done=0, sec_tick=0, cfg_ready=0, prescaler=0, blink=0. Duration registers load DEF_GREEN, DEF_YELLOW and DEF_RED.
- Reset asserted mid-phase aborts the phase at that edge. No phase_done is generated.
- Prescaler:
  - Counts 0..TICK_DIV-1 while state != IDLE-held and pause=0.
  - sec_tick=1 for the cycle in which the count wraps.
  - Prescaler clears on every phase entry, including a force_next entry, so each phase's first second is full length.
  - pause=1 holds both the prescaler and remain.
- cfg_ready=1 in every cycle after reset is released.
- Write on cfg_valid & cfg_ready:
  - The stored value is clamp(cfg_value, 1, MAX_SECOND): 0 becomes 1, and values above MAX_SECOND become MAX_SECOND.
  - cfg_sel=11 is dropped.
  - A write changes only the stored duration. The running remain is untouched; the new value applies at the next entry to that phase.
- States: IDLE, GREEN, YELLOW, RED. Light encoding: GREEN=001, YELLOW=010, RED=100.
- IDLE:
  - light = {0, blink, 0} and remain=0.
  - blink toggles on each sec_tick; the prescaler runs in IDLE unless pause=1.
  - start=1 -> GREEN on the next edge, with remain=green duration and phase_done=1.
- Running (GREEN, YELLOW, RED):
  - On sec_tick with remain>1: remain decrements by 1.
  - On sec_tick with remain==1: advance to the next phase, load its duration, phase_done=1.
  - force_next=1: same advance on that edge, regardless of remain or pause.
  - force_next coincident with an expiring tick produces exactly one advance, never two.
  - start=0 -> IDLE on the next edge, with blink=0 and phase_done=0. This has priority over force_next and the tick.
- Priority, per edge: reset > start=0 > force_next > sec_tick > hold.
- Every output is registered; the latency from any input to an output is 1 clk.
- remain never exceeds MAX_SECOND and never underflows below 1 while running.

Decomposition:
- Shared package traffic_pkg holds:
  - Phase state encoding: IDLE=2'd0, GREEN=2'd1, YELLOW=2'd2, RED=2'd3.
  - Light constants LIGHT_OFF, LIGHT_GREEN, LIGHT_YELLOW, LIGHT_RED.
  - The cfg_sel codes.
  - A clamp function for 7-bit durations.
- Sub-module sec_tick_gen holds the prescaler (ports: clk, rst_n, en, clr, tick). The sequencer FSM, duration registers and countdown stay in traffic_phase_sequencer.

Test Plan (TICK_DIV=4):
1. Reset, then start=1 -> light=001, remain=30. After 4 clk remain=29. After 120 clk from entry: light=010, remain=3, and phase_done pulses once.
2. Write green=5 (cfg_sel=00) during the first green phase -> the current remain is unaffected. The next GREEN entry has remain=5. Writes of 0 store 1; writes of 120 store 99.
3. force_next pulse while GREEN with remain=17 -> next edge: light=010, remain=3, phase_done=1, and the prescaler has restarted (next sec_tick arrives 4 clk later).
4. force_next asserted in the same cycle as the expiring tick of YELLOW (remain=1) -> a single transition to RED with remain=30, not to GREEN.
5. pause=1 for 20 clk while RED with remain=12 -> remain stays 12 and no sec_tick occurs. After release, a decrement arrives 4 clk later.
6. start=0 mid-phase -> IDLE with light=000, then light=010/000 alternating every 4 clk. Asserting rst_n=0 mid-RED for one edge -> all outputs return to their reset values and the durations return to 30/3/30.
